ram_arbiter: RTL

- Shares the single RAM socket between the CPU and the VGA controller.
- Arbitrates with round-robin, then latches the winner's command and drives one RAM transaction.
- Returns read data to the winner and signals completion with a one-cycle ack.
- Sits inside the bridge, between the CPU/VGA sockets and the RAM socket.

---
 rtl/ram_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU and the VGA reader.
// Define RAM_TIMEOUT_EN to abort RAM transactions that stay unacknowledged for TIMEOUT cycles.
module ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_ack,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req (and its command) until it sees its one-cycle
  // ack; the RAM sees ram_req held with a stable command until its one-cycle ram_ack.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VGA = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              grant_vga;
  logic              ram_req_d, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_d, vga_rdata_d;
  logic              cpu_ack_d, vga_ack_d, err_d;

`ifdef RAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_hit;

  // Fires in the TIMEOUT-th BUSY cycle that passes without ram_ack.
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    grant_vga   = 1'b0;
    ram_req_d   = ram_req;
    ram_we_d    = ram_we;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    cpu_rdata_d = cpu_rdata;
    vga_rdata_d = vga_rdata;
    cpu_ack_d   = 1'b0;
    vga_ack_d   = 1'b0;
    err_d       = 1'b0;
`ifdef RAM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req || vga_req) begin
          // On a tie the side that did not win last time goes first.
          grant_vga = vga_req && (!cpu_req || (last_q == OWN_CPU));
          owner_d   = grant_vga;
          last_d    = grant_vga;
          ram_req_d = 1'b1;
          if (grant_vga) begin
            ram_we_d    = 1'b0;
            ram_addr_d  = vga_addr;
            ram_wdata_d = '0;
          end else begin
            ram_we_d    = cpu_we;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
          end
`ifdef RAM_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ram_ack) begin
          ram_req_d = 1'b0;
          if (owner_q == OWN_VGA) begin
            vga_rdata_d = ram_rdata;
            vga_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = ram_rdata;
            cpu_ack_d   = 1'b1;
          end
          state_d = RESP;
        end
`ifdef RAM_TIMEOUT_EN
        else if (tmo_hit) begin
          ram_req_d = 1'b0;
          err_d     = 1'b1;
          if (owner_q == OWN_VGA) begin
            vga_rdata_d = '1;
            vga_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = '1;
            cpu_ack_d   = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_CPU;
      last_q    <= OWN_VGA;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_rdata <= '0;
      vga_rdata <= '0;
      cpu_ack   <= 1'b0;
      vga_ack   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      ram_req   <= ram_req_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      cpu_rdata <= cpu_rdata_d;
      vga_rdata <= vga_rdata_d;
      cpu_ack   <= cpu_ack_d;
      vga_ack   <= vga_ack_d;
      err       <= err_d;
    end
  end

`ifdef RAM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule
